// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv
//  Description : Small ALU with flag register and condition evaluation, plus
//                a sequential shift-add multiplier and restoring divider.
//                Single-cycle functions complete one cycle after start, and
//                MUL/DIVU/MODU complete dataBits+1 cycles after start.
//  Ports       : clk, reset (async, active-high)
//                start, func, aluA, aluB, updateFlags  - operation request
//                condition                             - condition to test
//                loadFlagsFromSavedState, savedFlags   - flag restore
//                aluOut, busy, done, divByZero, flags  - registered results
//                conditionHolds                        - condition outcome
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
    parameter int dataBits    = 16,
    parameter int counterBits = $clog2(dataBits) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [3:0]          func,
    input  logic [dataBits-1:0] aluA,
    input  logic [dataBits-1:0] aluB,
    input  logic                updateFlags,
    input  logic [3:0]          condition,
    input  logic                loadFlagsFromSavedState,
    input  logic [3:0]          savedFlags,
    output logic [dataBits-1:0] aluOut,
    output logic                busy,
    output logic                done,
    output logic                divByZero,
    output logic [3:0]          flags,
    output logic                conditionHolds
);

    localparam int MSB = dataBits - 1;

    localparam logic [3:0] FUNC_ADD     = 4'd0;
    localparam logic [3:0] FUNC_SUB     = 4'd1;
    localparam logic [3:0] FUNC_NOT     = 4'd2;
    localparam logic [3:0] FUNC_OR      = 4'd3;
    localparam logic [3:0] FUNC_AND     = 4'd4;
    localparam logic [3:0] FUNC_XOR     = 4'd5;
    localparam logic [3:0] FUNC_COMPARE = 4'd6;
    localparam logic [3:0] FUNC_MUL     = 4'd7;
    localparam logic [3:0] FUNC_DIVU    = 4'd8;
    localparam logic [3:0] FUNC_MODU    = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MUL    = 2'd1,
        S_DIV    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                 state_q;
    logic [3:0]             func_q;
    logic                   updFlags_q;
    logic [dataBits-1:0]    opB_q;      // multiplicand or divisor
    logic [dataBits-1:0]    hi_q;       // product high half or partial remainder
    logic [dataBits-1:0]    lo_q;       // multiplier/product low half or dividend/quotient
    logic [counterBits-1:0] cnt_q;
    logic [dataBits-1:0]    aluOut_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   divByZero_q;
    logic [3:0]             flags_q;    // {ZF,OF,SF,CF}

    // Unused encodings 10-15 behave as ADD
    logic [3:0] funcIn;
    assign funcIn = (func > FUNC_MODU) ? FUNC_ADD : func;

    // ------------------------------------------------------------------
    // Single-cycle datapath (operates directly on the input operands)
    // ------------------------------------------------------------------
    logic [dataBits:0]   addSum;
    logic [dataBits:0]   subSum;
    logic [dataBits-1:0] scRes;
    logic                scCf;
    logic                scOf;

    always_comb begin
        addSum = {1'b0, aluA} + {1'b0, aluB};
        subSum = {1'b0, aluA} + {1'b0, ~aluB} + {{dataBits{1'b0}}, 1'b1};
        scRes  = addSum[MSB:0];
        scCf   = addSum[dataBits];
        scOf   = (aluA[MSB] == aluB[MSB]) && (addSum[MSB] != aluA[MSB]);
        case (funcIn)
            FUNC_SUB, FUNC_COMPARE: begin
                scRes = subSum[MSB:0];
                scCf  = subSum[dataBits];
                scOf  = (aluA[MSB] != aluB[MSB]) && (subSum[MSB] != aluA[MSB]);
            end
            FUNC_NOT: begin
                scRes = ~aluA;
                scCf  = 1'b0;
                scOf  = 1'b0;
            end
            FUNC_OR: begin
                scRes = aluA | aluB;
                scCf  = 1'b0;
                scOf  = 1'b0;
            end
            FUNC_AND: begin
                scRes = aluA & aluB;
                scCf  = 1'b0;
                scOf  = 1'b0;
            end
            FUNC_XOR: begin
                scRes = aluA ^ aluB;
                scCf  = 1'b0;
                scOf  = 1'b0;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // One shift-add multiply step: add multiplicand into the high half
    // when the current multiplier LSB is set, then shift {hi,lo} right.
    // ------------------------------------------------------------------
    logic [dataBits:0]   mulSum;
    logic [dataBits-1:0] mulHi_d;
    logic [dataBits-1:0] mulLo_d;

    always_comb begin
        mulSum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opB_q} : '0);
        mulHi_d = mulSum[dataBits:1];
        mulLo_d = {mulSum[0], lo_q[MSB:1]};
    end

    // ------------------------------------------------------------------
    // One restoring-division step: shift the next dividend bit into the
    // remainder and subtract the divisor when it fits. The remainder is
    // always below the divisor, so the N-bit difference is exact.
    // ------------------------------------------------------------------
    logic [dataBits:0]   divShift;
    logic                divGe;
    logic [dataBits-1:0] divHi_d;
    logic [dataBits-1:0] divLo_d;

    always_comb begin
        divShift = {hi_q, lo_q[MSB]};
        divGe    = (divShift >= {1'b0, opB_q});
        divHi_d  = divGe ? (divShift[MSB:0] - opB_q) : divShift[MSB:0];
        divLo_d  = {lo_q[MSB-1:0], divGe};
    end

    // ------------------------------------------------------------------
    // Completion: decides when an operation finishes this cycle and what
    // result, flags and divide-by-zero status it reports.
    // ------------------------------------------------------------------
    logic                lastIter;
    logic                finValid;
    logic                finUpd;
    logic                finWrite;
    logic                finDbz;
    logic [dataBits-1:0] finRes;
    logic                finOf;
    logic                finCf;
    logic [3:0]          finFlags;

    assign lastIter = (cnt_q == counterBits'(dataBits - 1));

    always_comb begin
        finValid = 1'b0;
        finUpd   = updFlags_q;
        finWrite = 1'b1;
        finDbz   = 1'b0;
        finRes   = scRes;
        finOf    = scOf;
        finCf    = scCf;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    finUpd = updateFlags;
                    if (funcIn == FUNC_DIVU || funcIn == FUNC_MODU) begin
                        if (aluB == '0) begin
                            finValid = 1'b1;
                            finDbz   = 1'b1;
                            finRes   = (funcIn == FUNC_DIVU) ? '1 : aluA;
                            finOf    = 1'b1;
                            finCf    = 1'b0;
                        end
                    end else if (funcIn != FUNC_MUL) begin
                        finValid = 1'b1;
                        finWrite = (funcIn != FUNC_COMPARE);
                    end
                end
            end
            S_MUL: begin
                if (lastIter) begin
                    finValid = 1'b1;
                    finRes   = mulLo_d;
                    finCf    = |mulHi_d;
                    finOf    = |mulHi_d;
                end
            end
            S_DIV: begin
                if (lastIter) begin
                    finValid = 1'b1;
                    finRes   = (func_q == FUNC_DIVU) ? divLo_d : divHi_d;
                    finCf    = 1'b0;
                    finOf    = 1'b0;
                end
            end
            default: ;
        endcase
        finFlags = {(finRes == '0), finOf, finRes[MSB], finCf};
    end

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            func_q      <= 4'd0;
            updFlags_q  <= 1'b0;
            opB_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            aluOut_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            divByZero_q <= 1'b0;
            flags_q     <= 4'b0000;
        end else begin
            done_q <= 1'b0;
            if (finValid) begin
                done_q      <= 1'b1;
                divByZero_q <= finDbz;
                if (finWrite) begin
                    aluOut_q <= finRes;
                end
            end

            // A restore from saved state overrides a same-cycle commit
            if (loadFlagsFromSavedState) begin
                flags_q <= savedFlags;
            end else if (finValid && finUpd) begin
                flags_q <= finFlags;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        func_q     <= funcIn;
                        updFlags_q <= updateFlags;
                        cnt_q      <= '0;
                        hi_q       <= '0;
                        busy_q     <= 1'b1;
                        if (funcIn == FUNC_MUL) begin
                            state_q <= S_MUL;
                            lo_q    <= aluB;
                            opB_q   <= aluA;
                        end else if ((funcIn == FUNC_DIVU || funcIn == FUNC_MODU)
                                     && (aluB != '0)) begin
                            state_q <= S_DIV;
                            lo_q    <= aluA;
                            opB_q   <= aluB;
                        end else begin
                            state_q <= S_FINISH;
                        end
                    end
                end
                S_MUL: begin
                    hi_q  <= mulHi_d;
                    lo_q  <= mulLo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (lastIter) begin
                        state_q <= S_FINISH;
                    end
                end
                S_DIV: begin
                    hi_q  <= divHi_d;
                    lo_q  <= divLo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (lastIter) begin
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Condition evaluation on the current flags
    // ------------------------------------------------------------------
    logic fZ, fO, fS, fC;
    assign {fZ, fO, fS, fC} = flags_q;

    always_comb begin
        conditionHolds = 1'b0;
        case (condition)
            4'd0:  conditionHolds = 1'b1;
            4'd1:  conditionHolds = 1'b0;
            4'd2:  conditionHolds = fZ;
            4'd3:  conditionHolds = ~fZ;
            4'd4:  conditionHolds = fS;
            4'd5:  conditionHolds = fC & ~fZ;
            4'd6:  conditionHolds = ~fC | fZ;
            4'd7:  conditionHolds = fC;
            4'd8:  conditionHolds = ~fC;
            4'd9:  conditionHolds = ~fZ & (fS == fO);
            4'd10: conditionHolds = fZ | (fS != fO);
            4'd11: conditionHolds = (fS == fO);
            4'd12: conditionHolds = (fS != fO);
            4'd13: conditionHolds = fO;
            4'd14: conditionHolds = ~fO;
            default: conditionHolds = 1'b0;
        endcase
    end

    assign aluOut    = aluOut_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign divByZero = divByZero_q;
    assign flags     = flags_q;

endmodule
`default_nettype wire
